// File: rtl/mvau_weight_seq.sv
// mvau_weight_seq
//   Address sequencer for one MVAU weight memory bank (depth SF*NF, 1-cycle
//   registered read). Walks the bank with sf innermost, then nf, then output
//   pixel, and delivers a valid strobe plus fold-boundary flags that line up
//   with the memory's read data. The PE datapath can then accumulate and
//   flush without keeping its own counters.
//
// Ports
//   aclk       : clock, rising edge
//   areset     : asynchronous active-high reset
//   start      : one-cycle pulse that begins a frame (only honoured in IDLE)
//   in_v       : activation word for the current sf is available
//   stall      : downstream backpressure, blocks new issues only
//   wmem_addr  : registered weight memory address
//   w_v        : weight memory read data is valid this cycle
//   sf_last    : current beat is the last synapse fold (accumulator flush)
//   nf_last    : current beat is the last neuron fold
//   pix_last   : current beat belongs to the last output pixel
//   busy       : sequencer is not idle
//   done       : one-cycle pulse on the final beat of the frame
module mvau_weight_seq #(
  parameter int SF           = 2,
  parameter int NF           = 2,
  parameter int NUM_PIX      = 4,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    in_v,
  input  logic                    stall,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    w_v,
  output logic                    sf_last,
  output logic                    nf_last,
  output logic                    pix_last,
  output logic                    busy,
  output logic                    done
);

  // Counter widths are kept at least one bit so a fold of 1 still elaborates.
  localparam int SF_W  = (SF > 1)      ? $clog2(SF)      : 1;
  localparam int NF_W  = (NF > 1)      ? $clog2(NF)      : 1;
  localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  // The address counter replaces nf*SF+sf, so the bank must be exactly
  // SF*NF deep and addressable with the given width.
  if (WMEM_DEPTH != SF * NF) begin : g_bad_depth
    $error("mvau_weight_seq: WMEM_DEPTH must equal SF*NF");
  end
  if (WMEM_ADDR_BW < $clog2(WMEM_DEPTH)) begin : g_bad_addr_bw
    $error("mvau_weight_seq: WMEM_ADDR_BW too narrow for WMEM_DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic                    drain_cnt;
  logic [SF_W-1:0]         sf_cnt;
  logic [NF_W-1:0]         nf_cnt;
  logic [PIX_W-1:0]        pix_cnt;
  logic [WMEM_ADDR_BW-1:0] addr_cnt;

  // First pipe stage: travels with the registered address while the
  // memory performs its read.
  logic s1_v;
  logic s1_sf;
  logic s1_nf;
  logic s1_pix;

  logic issue;
  logic sf_at_end;
  logic nf_at_end;
  logic pix_at_end;
  logic final_beat;

  // stall has priority over in_v; only RUN may issue.
  assign issue      = (state == RUN) && in_v && !stall;
  assign sf_at_end  = (sf_cnt  == SF_W'(SF - 1));
  assign nf_at_end  = (nf_cnt  == NF_W'(NF - 1));
  assign pix_at_end = (pix_cnt == PIX_W'(NUM_PIX - 1));
  assign final_beat = sf_at_end && nf_at_end && pix_at_end;

  // Control FSM and issue counters. The address counter runs alongside the
  // fold counters and returns to 0 whenever the bank wraps (last sf of the
  // last nf), which is also why the counters are already clear when a
  // frame completes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      sf_cnt    <= '0;
      nf_cnt    <= '0;
      pix_cnt   <= '0;
      addr_cnt  <= '0;
      wmem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            sf_cnt   <= '0;
            nf_cnt   <= '0;
            pix_cnt  <= '0;
            addr_cnt <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            wmem_addr <= addr_cnt;
            addr_cnt  <= (sf_at_end && nf_at_end) ? '0
                                                   : addr_cnt + WMEM_ADDR_BW'(1);
            sf_cnt    <= sf_at_end ? '0 : sf_cnt + SF_W'(1);
            if (sf_at_end) begin
              nf_cnt <= nf_at_end ? '0 : nf_cnt + NF_W'(1);
              if (nf_at_end) begin
                pix_cnt <= pix_at_end ? '0 : pix_cnt + PIX_W'(1);
              end
            end
            if (final_beat) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the last issued beat clear the memory pipe.
          if (drain_cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage flag pipe matching the address register plus the memory's
  // registered read. Flags are gated by the valid bit so they are only ever
  // high together with w_v.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_v     <= 1'b0;
      s1_sf    <= 1'b0;
      s1_nf    <= 1'b0;
      s1_pix   <= 1'b0;
      w_v      <= 1'b0;
      sf_last  <= 1'b0;
      nf_last  <= 1'b0;
      pix_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      s1_v     <= issue;
      s1_sf    <= issue && sf_at_end;
      s1_nf    <= issue && nf_at_end;
      s1_pix   <= issue && pix_at_end;
      w_v      <= s1_v;
      sf_last  <= s1_sf;
      nf_last  <= s1_nf;
      pix_last <= s1_pix;
      done     <= s1_v && s1_sf && s1_nf && s1_pix;
    end
  end

endmodule

// File: tb/tb_mvau_weight_seq.sv
// tb_mvau_weight_seq
//   Directed bench for mvau_weight_seq. One instance uses SF=2, NF=2,
//   NUM_PIX=2; a second uses SF=1, NF=4, NUM_PIX=1. Stimulus pushes the
//   hand-derived expected beats (cycle, address, flags, done) into a queue
//   per instance; a negedge monitor pops and compares whenever w_v is high.
module tb_mvau_weight_seq;

  typedef struct {
    int cyc;
    int addr;
    int sf;
    int nf;
    int pix;
    int dn;
  } beat_t;

  logic       aclk = 1'b0;
  logic       areset;
  logic       start;
  logic       start_b;
  logic       in_v;
  logic       stall;

  logic [3:0] wmem_addr;
  logic       w_v, sf_last, nf_last, pix_last, busy, done;

  logic [1:0] wmem_addr_b;
  logic       w_v_b, sf_last_b, nf_last_b, pix_last_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  beat_t exp_q[$];
  beat_t exp_q_b[$];

  logic [3:0] prev_addr   = '0;
  logic [1:0] prev_addr_b = '0;

  // Beat k of one 2x2x2 frame, in sf-innermost order.
  int addr_tab[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int sf_tab[8]   = '{0, 1, 0, 1, 0, 1, 0, 1};
  int nf_tab[8]   = '{0, 0, 1, 1, 0, 0, 1, 1};
  int pix_tab[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
  int dn_tab[8]   = '{0, 0, 0, 0, 0, 0, 0, 1};

  mvau_weight_seq #(
    .SF(2), .NF(2), .NUM_PIX(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .in_v(in_v), .stall(stall),
    .wmem_addr(wmem_addr), .w_v(w_v), .sf_last(sf_last), .nf_last(nf_last),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  mvau_weight_seq #(
    .SF(1), .NF(4), .NUM_PIX(1), .WMEM_DEPTH(4), .WMEM_ADDR_BW(2)
  ) dut_b (
    .aclk(aclk), .areset(areset), .start(start_b), .in_v(in_v), .stall(stall),
    .wmem_addr(wmem_addr_b), .w_v(w_v_b), .sf_last(sf_last_b),
    .nf_last(nf_last_b), .pix_last(pix_last_b), .busy(busy_b), .done(done_b)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic pushBeat(input int c, input int k);
    beat_t b;
    b.cyc  = c;
    b.addr = addr_tab[k];
    b.sf   = sf_tab[k];
    b.nf   = nf_tab[k];
    b.pix  = pix_tab[k];
    b.dn   = dn_tab[k];
    exp_q.push_back(b);
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the
  // falling edge so the caller samples settled outputs.
  task automatic applyStimulus(input logic s, input logic sb, input logic iv,
                               input logic st, input logic rst);
    @(posedge aclk);
    #1;
    start   = s;
    start_b = sb;
    in_v    = iv;
    stall   = st;
    areset  = rst;
    @(negedge aclk);
  endtask

  // Scoreboard monitor for the 2x2x2 instance. The read data seen at a
  // cycle belongs to the address presented during the previous cycle.
  always @(negedge aclk) begin
    beat_t e;
    if (w_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got w_v=1 expected no beat (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("beat_cycle", cyc, e.cyc);
        checkOutput("beat_addr", 32'(prev_addr), e.addr);
        checkOutput("beat_sf_last", 32'(sf_last), e.sf);
        checkOutput("beat_nf_last", 32'(nf_last), e.nf);
        checkOutput("beat_pix_last", 32'(pix_last), e.pix);
        checkOutput("beat_done", 32'(done), e.dn);
      end
    end else if (done) begin
      checkOutput("done_without_w_v", 32'(done), 0);
    end
    prev_addr = wmem_addr;
  end

  // Scoreboard monitor for the SF=1, NF=4, NUM_PIX=1 instance.
  always @(negedge aclk) begin
    beat_t e;
    if (w_v_b) begin
      if (exp_q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat_b: got w_v=1 expected no beat (cycle %0d)", cyc);
      end else begin
        e = exp_q_b.pop_front();
        checkOutput("b_beat_cycle", cyc, e.cyc);
        checkOutput("b_beat_addr", 32'(prev_addr_b), e.addr);
        checkOutput("b_beat_sf_last", 32'(sf_last_b), e.sf);
        checkOutput("b_beat_nf_last", 32'(nf_last_b), e.nf);
        checkOutput("b_beat_pix_last", 32'(pix_last_b), e.pix);
        checkOutput("b_beat_done", 32'(done_b), e.dn);
      end
    end else if (done_b) begin
      checkOutput("b_done_without_w_v", 32'(done_b), 0);
    end
    prev_addr_b = wmem_addr_b;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    beat_t b;
    areset  = 1'b1;
    start   = 1'b0;
    start_b = 1'b0;
    in_v    = 1'b0;
    stall   = 1'b0;
    @(negedge aclk);
    checkOutput("reset_addr", 32'(wmem_addr), 0);
    checkOutput("reset_w_v", 32'(w_v), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);

    // Free-running frame: issues 1..8, beats 3..10, done at 10.
    $display("[TB] frame with continuous input");
    applyStimulus(1, 0, 1, 0, 0);
    t0 = cyc;
    for (int k = 0; k < 8; k++) pushBeat(t0 + 3 + k, k);
    checkOutput("A_busy_c0", 32'(busy), 0);
    for (int r = 1; r <= 12; r++) begin
      applyStimulus(0, 0, 1, 0, 0);
      if (r == 1)  checkOutput("A_busy_c1", 32'(busy), 1);
      if (r == 2)  checkOutput("A_addr_c2", 32'(wmem_addr), 0);
      if (r == 10) checkOutput("A_busy_c10", 32'(busy), 1);
      if (r == 11) checkOutput("A_busy_c11", 32'(busy), 0);
    end
    checkOutput("A_beats_left", exp_q.size(), 0);

    // in_v low in cycles 3..5: beats at 3,4 then 8..13, done at 13.
    $display("[TB] frame with input gap");
    applyStimulus(1, 0, 1, 0, 0);
    t0 = cyc;
    for (int k = 0; k < 8; k++) pushBeat(t0 + ((k < 2) ? 3 + k : 6 + k), k);
    for (int r = 1; r <= 15; r++) begin
      applyStimulus(0, 0, !(r >= 3 && r <= 5), 0, 0);
      if (r == 5)  checkOutput("B_addr_hold", 32'(wmem_addr), 1);
      if (r == 13) checkOutput("B_busy_c13", 32'(busy), 1);
      if (r == 14) checkOutput("B_busy_c14", 32'(busy), 0);
    end
    checkOutput("B_beats_left", exp_q.size(), 0);

    // stall in cycles 4..6: beats at 3,4,5 then 9..13, done at 13.
    $display("[TB] frame with stall");
    applyStimulus(1, 0, 1, 0, 0);
    t0 = cyc;
    for (int k = 0; k < 8; k++) pushBeat(t0 + ((k < 3) ? 3 + k : 6 + k), k);
    for (int r = 1; r <= 15; r++) begin
      applyStimulus(0, 0, 1, (r >= 4 && r <= 6), 0);
      if (r == 6)  checkOutput("C_addr_hold", 32'(wmem_addr), 2);
      if (r == 14) checkOutput("C_busy_c14", 32'(busy), 0);
    end
    checkOutput("C_beats_left", exp_q.size(), 0);

    // Reset at cycle 5 drops the beats from issues 3 and 4; restart at 8.
    $display("[TB] reset mid-frame then restart");
    applyStimulus(1, 0, 1, 0, 0);
    t0 = cyc;
    pushBeat(t0 + 3, 0);
    pushBeat(t0 + 4, 1);
    for (int k = 0; k < 8; k++) pushBeat(t0 + 11 + k, k);
    for (int r = 1; r <= 20; r++) begin
      applyStimulus((r == 8), 0, 1, 0, (r == 5));
      if (r == 5) begin
        checkOutput("D_rst_addr", 32'(wmem_addr), 0);
        checkOutput("D_rst_w_v", 32'(w_v), 0);
        checkOutput("D_rst_busy", 32'(busy), 0);
        checkOutput("D_rst_flags", 32'({sf_last, nf_last, pix_last, done}), 0);
      end
      if (r == 7)  checkOutput("D_busy_c7", 32'(busy), 0);
      if (r == 18) checkOutput("D_busy_c18", 32'(busy), 1);
    end
    checkOutput("D_beats_left", exp_q.size(), 0);

    // start at 4 is ignored; start at 11 (first IDLE cycle) is accepted.
    $display("[TB] ignored start then back-to-back frame");
    applyStimulus(1, 0, 1, 0, 0);
    t0 = cyc;
    for (int k = 0; k < 8; k++) pushBeat(t0 + 3 + k, k);
    for (int k = 0; k < 8; k++) pushBeat(t0 + 14 + k, k);
    for (int r = 1; r <= 23; r++) begin
      applyStimulus((r == 4 || r == 11), 0, 1, 0, 0);
      if (r == 11) checkOutput("E_busy_c11", 32'(busy), 0);
      if (r == 12) checkOutput("E_busy_c12", 32'(busy), 1);
      if (r == 22) checkOutput("E_busy_c22", 32'(busy), 0);
    end
    checkOutput("E_beats_left", exp_q.size(), 0);

    // SF=1, NF=4, NUM_PIX=1: beats at 3..6, sf_last and pix_last always.
    $display("[TB] degenerate fold instance");
    applyStimulus(0, 1, 1, 0, 0);
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      b.cyc  = t0 + 3 + k;
      b.addr = k;
      b.sf   = 1;
      b.nf   = (k == 3) ? 1 : 0;
      b.pix  = 1;
      b.dn   = (k == 3) ? 1 : 0;
      exp_q_b.push_back(b);
    end
    for (int r = 1; r <= 9; r++) begin
      applyStimulus(0, 0, 1, 0, 0);
      if (r == 6) checkOutput("F_busy_c6", 32'(busy_b), 1);
      if (r == 7) checkOutput("F_busy_c7", 32'(busy_b), 0);
    end
    checkOutput("F_beats_left", exp_q_b.size(), 0);
    checkOutput("F_main_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
